// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared default widths and depth helper for sync_fifo_wl
// Contents:
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default word width and pointer width
//   fifo_depth()                    : number of words for a given pointer width
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_ADDR_WIDTH = 8;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage, sync write, sync or async read
// Ports:
//   clk   : write clock, and read clock in sync-read mode
//   rst   : async active-high reset of the read register (sync-read mode only)
//   we    : write strobe, stores wdata at waddr
//   waddr : write address
//   wdata : write word
//   re    : read strobe, loads mem[raddr] into rdata (sync-read mode only)
//   raddr : read address
//   rdata : read word (registered, or combinational when ASYNC_RD=1)
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit ASYNC_RD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  // Array deliberately has no reset so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (ASYNC_RD) begin : g_async_rd
      assign rdata = mem[raddr];
      // Read strobe and reset only matter for the registered read port.
      logic unused_sync_ctl;
      assign unused_sync_ctl = re ^ rst;
    end else begin : g_sync_rd
      // Holds its value between accepted reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata <= '0;
        end else if (re) begin
          rdata <= mem[raddr];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_wl.sv
// rtl/sync_fifo_wl.sv - synchronous FIFO with water level, runtime thresholds and sticky errors
// Ports:
//   clk, rst            : single clock, async active-high reset
//   wr_data, wr_en      : write side; write accepted when wr_en && !full
//   full, almost_full   : level == DEPTH, level >= af_thresh
//   rd_en, rd_data      : read side; read accepted when rd_en && !empty
//   empty, almost_empty : level == 0, level <= ae_thresh
//   af_thresh, ae_thresh: runtime thresholds, effective the same cycle
//   water_level         : words stored, 0..DEPTH
//   overflow, underflow : sticky error flags, cleared by clr_err
//   clr_err             : clears error flags (a new error the same cycle wins)
module sync_fifo_wl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int OUT_REG    = 0,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   water_level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LEVEL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags come straight from the registered level, so a write never
  // shows through to empty in the same cycle.
  assign full         = (level == LEVEL_MAX);
  assign empty        = (level == '0);
  assign almost_full  = (level >= af_thresh);
  assign almost_empty = (level <= ae_thresh);
  assign water_level  = level;

  // Blocking is decided from the current level only: a read at empty is
  // refused even with a concurrent write, and likewise a write at full.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        level <= level + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ASYNC_RD   (FWFT != 0)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Gating on empty keeps stale array contents (including words
      // written before a reset) off the output.
      assign rd_data = empty ? '0 : ram_rdata;
    end else if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= '0;
        end else begin
          out_q <= ram_rdata;
        end
      end
      assign rd_data = out_q;
    end else begin : g_direct
      assign rd_data = ram_rdata;
    end
  endgenerate

endmodule
